// File: rtl/countone_hls_deadlock_report_pkg.sv
// Shared types and default widths for the countone deadlock report path.
// FSM encodings are visible to software through state_dbg, so they are pinned.
package countone_hls_deadlock_pkg;

    localparam int DEF_INFO_W = 9;
    localparam int DEF_TS_W   = 32;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILTER  = 2'd1,
        ST_LATCHED = 2'd2,
        ST_REARM   = 2'd3
    } state_e;

endpackage

// File: rtl/countone_hls_deadlock_report_if.sv
// Bundle between the upstream deadlock monitor / register wrapper and the report block.
// master drives monitor flags and ack; slave returns the latched report.
interface countone_hls_deadlock_report_if
    import countone_hls_deadlock_pkg::*;
#(
    parameter int INFO_W = DEF_INFO_W,
    parameter int TS_W   = DEF_TS_W,
    parameter int CNT_W  = DEF_CNT_W
);
  logic              enable;
  logic              block;
  logic [INFO_W-1:0] axis_block_info;
  logic              ack;
  logic              deadlock;
  logic [INFO_W-1:0] report_info;
  logic [TS_W-1:0]   report_time;
  logic [CNT_W-1:0]  report_count;
  logic [1:0]        state_dbg;

  modport master (
    output enable, block, axis_block_info, ack,
    input  deadlock, report_info, report_time, report_count, state_dbg
  );

  modport slave (
    input  enable, block, axis_block_info, ack,
    output deadlock, report_info, report_time, report_count, state_dbg
  );
endinterface

// File: rtl/countone_hls_deadlock_report_filter.sv
// Persistence counter: counts consecutive qualified block samples.
// hit is combinational on the FILTER_LEN-th sample so the caller can act on that same edge.
module countone_hls_deadlock_filter #(
    parameter int FILTER_LEN = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic hit
);
  localparam int RUN_W = $clog2(FILTER_LEN + 1);
  localparam logic [RUN_W-1:0] LAST = RUN_W'(FILTER_LEN - 1);

  logic [RUN_W-1:0] run;

  // run holds the number of highs already seen, so the current sample is the (run+1)-th
  assign hit = inc && (run == LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      run <= '0;
    end else if (clear) begin
      run <= '0;
    end else if (inc) begin
      run <= run + RUN_W'(1);
    end
  end
endmodule

// File: rtl/countone_hls_deadlock_report.sv
// Filters the monitor's block flag, declares a deadlock and holds a report until ack.
// Declaration edge is the FILTER_LEN-th consecutive high sample; deadlock rises after it.
module countone_hls_deadlock_report
    import countone_hls_deadlock_pkg::*;
#(
    parameter int INFO_W     = DEF_INFO_W,
    parameter int FILTER_LEN = 16,
    parameter int TS_W       = DEF_TS_W,
    parameter int CNT_W      = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  countone_hls_deadlock_report_if.slave bus
);
  state_e            state;
  logic [TS_W-1:0]   ts;
  logic              deadlock_q;
  logic [INFO_W-1:0] info_q;
  logic [TS_W-1:0]   time_q;
  logic [CNT_W-1:0]  cnt_q;

  logic armed;
  logic fire;
  logic hit;

  assign armed = (state == ST_IDLE) || (state == ST_FILTER);
  assign fire  = armed && bus.enable && bus.block;

  // Any gap in the qualified run, or leaving the armed states, restarts the count
  countone_hls_deadlock_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clock (clock),
    .reset (reset),
    .clear (!fire || hit),
    .inc   (fire),
    .hit   (hit)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ts         <= '0;
      deadlock_q <= 1'b0;
      info_q     <= '0;
      time_q     <= '0;
      cnt_q      <= '0;
    end else begin
      if (bus.enable) begin
        ts <= ts + TS_W'(1);
      end
      case (state)
        ST_IDLE, ST_FILTER: begin
          if (fire) begin
            if (hit) begin
              state      <= ST_LATCHED;
              deadlock_q <= 1'b1;
              info_q     <= bus.axis_block_info;
              time_q     <= ts;
              if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else begin
              state <= ST_FILTER;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LATCHED: begin
          // Accumulate channels that join the stall after declaration
          info_q <= info_q | bus.axis_block_info;
          if (bus.ack) begin
            state      <= ST_REARM;
            deadlock_q <= 1'b0;
          end
        end
        ST_REARM: begin
          // Wait for the acknowledged stall to clear before re-arming
          if (!bus.block) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.deadlock     = deadlock_q;
  assign bus.report_info  = info_q;
  assign bus.report_time  = time_q;
  assign bus.report_count = cnt_q;
  assign bus.state_dbg    = state;
endmodule

// File: tb/tb_countone_hls_deadlock_report.sv
// Directed bench: expected declarations go into a scoreboard, a negedge monitor checks them.
module tb_countone_hls_deadlock_report;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  countone_hls_deadlock_report_if #(.INFO_W(9), .TS_W(32), .CNT_W(8)) bus0 ();
  countone_hls_deadlock_report_if #(.INFO_W(9), .TS_W(32), .CNT_W(8)) bus1 ();

  countone_hls_deadlock_report #(.INFO_W(9), .FILTER_LEN(16), .TS_W(32), .CNT_W(8)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  countone_hls_deadlock_report #(.INFO_W(9), .FILTER_LEN(1), .TS_W(32), .CNT_W(8)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [8:0]  info;
    logic [31:0] t;
    logic [7:0]  cnt;
    int unsigned edge_n;
  } exp_t;
  exp_t sb[$];

  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [8:0] info, input logic [31:0] t, input logic [7:0] cnt,
                      input int unsigned e);
    exp_t x;
    x.info   = info;
    x.t      = t;
    x.cnt    = cnt;
    x.edge_n = e;
    sb.push_back(x);
  endtask

  // Monitor: every rising deadlock on dut0 must match the oldest expected declaration
  logic dl_prev = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (bus0.deadlock && !dl_prev) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_declaration: deadlock rose at edge %0d, none expected", cyc);
      end else begin
        e = sb.pop_front();
        chk("decl_info",  64'(bus0.report_info),  64'(e.info));
        chk("decl_time",  64'(bus0.report_time),  64'(e.t));
        chk("decl_count", 64'(bus0.report_count), 64'(e.cnt));
        chk("decl_edge",  64'(cyc),               64'(e.edge_n));
      end
    end
    dl_prev = bus0.deadlock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.enable = 0; bus0.block = 0; bus0.axis_block_info = '0; bus0.ack = 0;
    bus1.enable = 0; bus1.block = 0; bus1.axis_block_info = '0; bus1.ack = 0;

    // Reset for edges 1..2
    ticks(2);
    chk("rst_deadlock", 64'(bus0.deadlock),     0);
    chk("rst_info",     64'(bus0.report_info),  0);
    chk("rst_time",     64'(bus0.report_time),  0);
    chk("rst_count",    64'(bus0.report_count), 0);
    chk("rst_state",    64'(bus0.state_dbg),    0);

    // Quiet enabled run, edges 3..52: ts reaches 50
    reset = 1; bus0.enable = 1;
    ticks(50);
    chk("quiet_deadlock", 64'(bus0.deadlock),  0);
    chk("quiet_state",    64'(bus0.state_dbg), 0);

    // Sustained block from edge 53: declaration at edge 68 with ts 65
    bus0.block = 1; bus0.axis_block_info = 9'h1F8;
    push(9'h1F8, 32'd65, 8'd1, 68);
    ticks(15);
    chk("filter_state",    64'(bus0.state_dbg), 1);
    chk("filter_deadlock", 64'(bus0.deadlock),  0);
    tick();
    chk("latched_state", 64'(bus0.state_dbg), 2);

    // Late channel joins while latched
    bus0.axis_block_info = 9'h007;
    tick();
    chk("or_accum_info", 64'(bus0.report_info), 9'h1FF);
    bus0.ack = 1;
    tick();
    chk("ack_deadlock", 64'(bus0.deadlock),  0);
    chk("ack_state",    64'(bus0.state_dbg), 3);
    bus0.ack = 0;
    ticks(2);
    chk("rearm_hold_state",    64'(bus0.state_dbg), 3);
    chk("rearm_hold_deadlock", 64'(bus0.deadlock),  0);
    bus0.block = 0; bus0.axis_block_info = '0;
    tick();
    chk("rearm_exit_state", 64'(bus0.state_dbg),    0);
    chk("report_held_info", 64'(bus0.report_info),  9'h1FF);
    chk("report_held_cnt",  64'(bus0.report_count), 1);

    // 15-high burst (edges 74..88) is filtered out, gap at 89, 16-high burst declares at 105
    bus0.block = 1; bus0.axis_block_info = 9'h03A;
    ticks(15);
    chk("burst15_state",    64'(bus0.state_dbg), 1);
    chk("burst15_deadlock", 64'(bus0.deadlock),  0);
    bus0.block = 0; bus0.axis_block_info = '0;
    tick();
    chk("gap_state", 64'(bus0.state_dbg), 0);
    bus0.block = 1; bus0.axis_block_info = 9'h03A;
    push(9'h03A, 32'd102, 8'd2, 105);
    ticks(15);
    chk("burst16_pre_deadlock", 64'(bus0.deadlock), 0);
    tick();
    chk("burst16_deadlock", 64'(bus0.deadlock), 1);
    bus0.ack = 1; bus0.block = 0; bus0.axis_block_info = '0;
    tick();
    chk("ack2_state", 64'(bus0.state_dbg), 3);
    bus0.ack = 0;
    tick();
    chk("rearm2_exit_state", 64'(bus0.state_dbg), 0);

    // enable drops mid-filter (edge 113); ts frozen through edge 117
    bus0.block = 1; bus0.axis_block_info = 9'h1C0;
    ticks(5);
    chk("mid_filter_state", 64'(bus0.state_dbg), 1);
    bus0.enable = 0;
    tick();
    chk("disable_state", 64'(bus0.state_dbg), 0);
    ticks(4);
    chk("disabled_idle_state", 64'(bus0.state_dbg), 0);
    bus0.enable = 1;
    push(9'h1C0, 32'd125, 8'd3, 133);
    ticks(16);
    chk("third_decl_deadlock", 64'(bus0.deadlock),  1);
    chk("third_decl_state",    64'(bus0.state_dbg), 2);

    // Reset while latched drops the pending report
    reset = 0;
    tick();
    chk("rst2_deadlock", 64'(bus0.deadlock),     0);
    chk("rst2_info",     64'(bus0.report_info),  0);
    chk("rst2_time",     64'(bus0.report_time),  0);
    chk("rst2_count",    64'(bus0.report_count), 0);
    chk("rst2_state",    64'(bus0.state_dbg),    0);
    reset = 1; bus0.enable = 0; bus0.block = 0; bus0.axis_block_info = '0;
    tick();
    chk("scoreboard_drained", 64'(sb.size()), 0);

    // FILTER_LEN=1 instance: immediate declaration, then saturate the counter
    bus1.enable = 1; bus1.block = 1; bus1.axis_block_info = 9'h005;
    tick();
    chk("fl1_deadlock", 64'(bus1.deadlock),     1);
    chk("fl1_state",    64'(bus1.state_dbg),    2);
    chk("fl1_info",     64'(bus1.report_info),  9'h005);
    chk("fl1_count",    64'(bus1.report_count), 1);
    for (int i = 1; i <= 299; i++) begin
      bus1.ack = 1; bus1.block = 0; bus1.axis_block_info = '0;
      tick();
      bus1.ack = 0;
      tick();
      bus1.block = 1; bus1.axis_block_info = 9'h005;
      tick();
      if (i == 200) chk("fl1_count_mid", 64'(bus1.report_count), 201);
    end
    chk("fl1_count_sat", 64'(bus1.report_count), 255);
    chk("fl1_sat_deadlock", 64'(bus1.deadlock), 1);
    chk("fl1_last_time", 64'(bus1.report_time), 897);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
